// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Used by dmem_access_ctrl and dmem_lane_steer; no build-time options live here.
package dmem_access_ctrl_pkg;

  localparam int kADDR_W        = 32;
  localparam int kDATA_W        = 32;
  localparam int kBYTE_LANES    = 4;
  localparam int kWORD_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  typedef struct packed {
    logic                   we;
    logic [kADDR_W-1:0]     addr;
    logic [kDATA_W-1:0]     wdata;
    logic [kBYTE_LANES-1:0] be;
  } dmem_req_s;

  // Lanes touched by an access: all four for a word, one for a byte.
  function automatic logic [kBYTE_LANES-1:0] lane_mask(
    input logic                      is_byte,
    input logic [kWORD_ADDR_LSB-1:0] lane
  );
    logic [kBYTE_LANES-1:0] mask;
    mask = is_byte ? ({{(kBYTE_LANES-1){1'b0}}, 1'b1} << lane) : {kBYTE_LANES{1'b1}};
    return mask;
  endfunction

endpackage : dmem_access_ctrl_pkg

// File: rtl/dmem_access_ctrl_lane_steer.sv
// Combinational byte-lane steering. STORE_DIR=1: replicate the store byte across
// all lanes; STORE_DIR=0: pick the addressed lane of a load word and zero-extend it.
module dmem_lane_steer
  import dmem_access_ctrl_pkg::*;
#(
  parameter bit STORE_DIR = 1'b1
) (
  input  logic                      is_byte_i,
  input  logic [kWORD_ADDR_LSB-1:0] lane_i,
  input  logic [kDATA_W-1:0]        data_i,
  output logic [kDATA_W-1:0]        data_o,
  output logic [kBYTE_LANES-1:0]    be_o
);

  assign be_o = lane_mask(is_byte_i, lane_i);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    data_o = data_i;
    if (is_byte_i) begin
      if (STORE_DIR) begin
        data_o = {kBYTE_LANES{data_i[7:0]}};
      end else begin
        data_o = {{(kDATA_W-8){1'b0}}, data_i[{lane_i, 3'b000} +: 8]};
      end
    end
  end

endmodule : dmem_lane_steer

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data access sequencer: one valid/ready request per load/store, pipeline
// stall until retirement, SB lane steering and LBU zero-extension. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = kADDR_W,
  parameter int DATA_W = kDATA_W
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   mem_op_v_i,
  input  logic                   is_load_op_i,
  input  logic                   is_store_op_i,
  input  logic                   is_byte_op_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      store_data_i,
  output logic                   stall_o,
  output logic [DATA_W-1:0]      load_data_o,
  output logic                   load_data_v_o,
  output logic                   op_done_o,
  output logic                   mem_req_v_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_we_o,
  output logic [ADDR_W-1:0]      mem_req_addr_o,
  output logic [DATA_W-1:0]      mem_req_wdata_o,
  output logic [kBYTE_LANES-1:0] mem_req_be_o,
  input  logic                   mem_resp_v_i,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic                   misalign_o,
`endif
  input  logic [DATA_W-1:0]      mem_resp_data_i
);

  dmem_state_e                 state_q, state_d;
  dmem_req_s                   req_q, req_d;
  logic                        is_load_q;
  logic                        is_byte_q;
  logic [kWORD_ADDR_LSB-1:0]   lane_q;
  logic [DATA_W-1:0]           load_data_q;
  logic                        trapped;

  logic                        accept;
  logic                        take_load;
  logic                        misalign_hit;
  logic                        resp_take;
  logic [DATA_W-1:0]           st_wdata;
  logic [kBYTE_LANES-1:0]      st_be;
  logic [DATA_W-1:0]           ld_data;
  logic [kBYTE_LANES-1:0]      ld_lanes;

  assign accept    = mem_op_v_i & (is_load_op_i | is_store_op_i);
  // A decode with both flags set is a store.
  assign take_load = is_load_op_i & ~is_store_op_i;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign_hit = ~is_byte_op_i & (addr_i[kWORD_ADDR_LSB-1:0] != '0);
  assign trapped      = misalign_q;
  assign misalign_o   = (state_q == DONE) & misalign_q;
`else
  assign misalign_hit = 1'b0;
  assign trapped      = 1'b0;
`endif

  // Responses only count in WAIT; a stray one after an abandoned access is dropped.
  assign resp_take = (state_q == WAIT) & mem_resp_v_i & (|ld_lanes);

  dmem_lane_steer #(.STORE_DIR(1'b1)) u_store_steer (
    .is_byte_i (is_byte_op_i),
    .lane_i    (addr_i[kWORD_ADDR_LSB-1:0]),
    .data_i    (store_data_i),
    .data_o    (st_wdata),
    .be_o      (st_be)
  );

  dmem_lane_steer #(.STORE_DIR(1'b0)) u_load_steer (
    .is_byte_i (is_byte_q),
    .lane_i    (lane_q),
    .data_i    (mem_resp_data_i),
    .data_o    (ld_data),
    .be_o      (ld_lanes)
  );

  // Request captured at accept; low address bits drop so words align by truncation.
  always_comb begin
    req_d       = '0;
    req_d.we    = ~take_load;
    req_d.addr  = {addr_i[ADDR_W-1:kWORD_ADDR_LSB], {kWORD_ADDR_LSB{1'b0}}};
    req_d.wdata = st_wdata;
    req_d.be    = st_be;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = misalign_hit ? DONE : REQ;
      REQ:     if (mem_req_ready_i) state_d = is_load_q ? WAIT : DONE;
      WAIT:    if (resp_take) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and clears every register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      is_load_q   <= 1'b0;
      is_byte_q   <= 1'b0;
      lane_q      <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && accept) begin
        req_q     <= req_d;
        is_load_q <= take_load;
        is_byte_q <= is_byte_op_i;
        lane_q    <= addr_i[kWORD_ADDR_LSB-1:0];
      end
      if (resp_take) begin
        load_data_q <= ld_data;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      misalign_q <= 1'b0;
    end else if ((state_q == IDLE) && accept) begin
      misalign_q <= misalign_hit;
    end
  end
`endif

  assign stall_o = ((state_q == IDLE) & accept) | (state_q == REQ) | (state_q == WAIT);

  assign op_done_o       = (state_q == DONE);
  assign load_data_v_o   = (state_q == DONE) & is_load_q & ~trapped;
  assign load_data_o     = load_data_q;

  assign mem_req_v_o     = (state_q == REQ);
  assign mem_req_we_o    = req_q.we;
  assign mem_req_addr_o  = req_q.addr;
  assign mem_req_wdata_o = req_q.wdata;
  assign mem_req_be_o    = req_q.be;

endmodule : dmem_access_ctrl

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: transaction-level model compared every cycle,
// plus directed literal checks. Exercises DMEM_MISALIGN_TRAP_EN when that macro is defined.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        mem_op_v_i, is_load_op_i, is_store_op_i, is_byte_op_i;
  logic [31:0] addr_i, store_data_i;
  logic        stall_o, load_data_v_o, op_done_o, mem_req_v_o, mem_req_ready_i, mem_req_we_o;
  logic [31:0] load_data_o, mem_req_addr_o, mem_req_wdata_o, mem_resp_data_i;
  logic [3:0]  mem_req_be_o;
  logic        mem_resp_v_i;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .mem_op_v_i      (mem_op_v_i),
    .is_load_op_i    (is_load_op_i),
    .is_store_op_i   (is_store_op_i),
    .is_byte_op_i    (is_byte_op_i),
    .addr_i          (addr_i),
    .store_data_i    (store_data_i),
    .stall_o         (stall_o),
    .load_data_o     (load_data_o),
    .load_data_v_o   (load_data_v_o),
    .op_done_o       (op_done_o),
    .mem_req_v_o     (mem_req_v_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_be_o    (mem_req_be_o),
    .mem_resp_v_i    (mem_resp_v_i),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign_o      (misalign_o),
`endif
    .mem_resp_data_i (mem_resp_data_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access in flight, tracked as "handshake seen" and
  // "retiring this cycle" flags; expected outputs follow from plain arithmetic.
  logic        m_busy, m_hs, m_retire, m_ld, m_byte, m_trap;
  logic [31:0] m_addr, m_data, m_ld_data;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_busy <= 0; m_hs <= 0; m_retire <= 0; m_ld <= 0; m_byte <= 0; m_trap <= 0;
      m_addr <= 0; m_data <= 0; m_ld_data <= 0;
    end else if (m_retire) begin
      m_retire <= 0;
      m_busy   <= 0;
    end else if (!m_busy) begin
      if (mem_op_v_i && (is_load_op_i || is_store_op_i)) begin
        m_busy <= 1;
        m_hs   <= 0;
        m_ld   <= is_load_op_i && !is_store_op_i;
        m_byte <= is_byte_op_i;
        m_addr <= addr_i;
        m_data <= store_data_i;
        m_trap <= 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!is_byte_op_i && (addr_i % 4) != 0) begin
          m_trap   <= 1;
          m_retire <= 1;
        end
`endif
      end
    end else if (!m_hs) begin
      if (mem_req_ready_i) begin
        m_hs <= 1;
        if (!m_ld) m_retire <= 1;
      end
    end else if (mem_resp_v_i) begin
      m_ld_data <= m_byte ? ((mem_resp_data_i >> (8 * (m_addr % 4))) & 32'hFF) : mem_resp_data_i;
      m_retire  <= 1;
    end
  end

  logic        e_stall, e_req;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  assign e_stall = (!m_busy && mem_op_v_i && (is_load_op_i || is_store_op_i)) || (m_busy && !m_retire);
  assign e_req   = m_busy && !m_hs && !m_retire;
  assign e_addr  = m_addr & ~32'h3;
  assign e_wdata = m_byte ? (m_data & 32'hFF) * 32'h0101_0101 : m_data;
  assign e_be    = m_byte ? 4'(1 << (m_addr % 4)) : 4'hF;

  always @(negedge clk) begin
    check("cyc_stall", stall_o, e_stall);
    check("cyc_op_done", op_done_o, m_retire);
    check("cyc_load_v", load_data_v_o, m_retire && m_ld && !m_trap);
    check("cyc_load_data", load_data_o, m_ld_data);
    check("cyc_req_v", mem_req_v_o, e_req);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("cyc_misalign", misalign_o, m_retire && m_trap);
`endif
    if (e_req) begin
      check("cyc_req_we", mem_req_we_o, !m_ld);
      check("cyc_req_addr", mem_req_addr_o, e_addr);
      if (!m_ld) begin
        check("cyc_req_wdata", mem_req_wdata_o, e_wdata);
        check("cyc_req_be", mem_req_be_o, e_be);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Results of the last run_op.
  int          r_done_at, r_stall, r_hs, r_ldv, r_reqv;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;

  task automatic idle_inputs();
    mem_op_v_i = 0; is_load_op_i = 0; is_store_op_i = 0; is_byte_op_i = 0;
    addr_i = 0; store_data_i = 0; mem_req_ready_i = 0; mem_resp_v_i = 0;
    mem_resp_data_i = 32'h5A5A_0F0F;
  endtask

  // Accept at cycle 1, ready after rd low cycles, response rsd cycles after the earliest
  // legal slot. The retiring instruction is re-presented in its DONE cycle.
  task automatic run_op(input logic ld, input logic st, input logic byt,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int rd, input int rsd, input logic [31:0] rdata);
    int   resp_cyc, exp_done;
    logic eff_ld;
    eff_ld   = ld && !st;
    resp_cyc = 3 + rd + rsd;
    exp_done = eff_ld ? resp_cyc + 1 : 3 + rd;
    r_done_at = 0; r_stall = 0; r_hs = 0; r_ldv = 0; r_reqv = 0;
    r_addr = 0; r_wdata = 0; r_be = 0;
    for (int k = 1; k <= 40; k++) begin
      mem_op_v_i      = (k == 1) || (k == exp_done);
      is_load_op_i    = ld;
      is_store_op_i   = st;
      is_byte_op_i    = byt;
      addr_i          = addr;
      store_data_i    = data;
      mem_req_ready_i = (k == 2 + rd);
      mem_resp_v_i    = eff_ld && (k == resp_cyc);
      mem_resp_data_i = mem_resp_v_i ? rdata : 32'h5A5A_0F0F;
      @(negedge clk);
      if (stall_o) r_stall++;
      if (load_data_v_o) r_ldv++;
      if (mem_req_v_o) begin
        r_reqv++;
        r_addr  = mem_req_addr_o;
        r_wdata = mem_req_wdata_o;
        r_be    = mem_req_be_o;
        if (mem_req_ready_i) r_hs++;
      end
      if (op_done_o && r_done_at == 0) r_done_at = k;
      @(posedge clk); #1;
      if (r_done_at != 0) break;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    n_reset = 1;
    #1 n_reset = 0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_load_data", load_data_o, 32'h0);
    check("rst_req_v", mem_req_v_o, 1'b0);
    check("rst_req_fields", {mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o}, 69'h0);
    @(posedge clk); #1;
    n_reset = 1;
    @(posedge clk); #1;

    // SW: 3-cycle store, stall for 2.
    run_op(0, 1, 0, 32'h104, 32'hDEAD_BEEF, 0, 0, 0);
    check("sw_done_at", r_done_at, 3);
    check("sw_stall_cycles", r_stall, 2);
    check("sw_handshakes", r_hs, 1);
    check("sw_req", {r_addr, r_wdata, r_be}, {32'h104, 32'hDEAD_BEEF, 4'hF});

    // SB into lane 3.
    run_op(0, 1, 1, 32'h107, 32'h0000_00A5, 0, 0, 0);
    check("sb_req", {r_addr, r_wdata, r_be}, {32'h104, 32'hA5A5_A5A5, 4'b1000});
    check("sb_done_at", r_done_at, 3);

    // LBU lane 2, three idle WAIT cycles.
    run_op(1, 0, 1, 32'h202, 0, 0, 3, 32'h1122_3344);
    check("lbu_data", load_data_o, 32'h22);
    check("lbu_done_at", r_done_at, 7);
    check("lbu_stall_cycles", r_stall, 6);
    check("lbu_load_v_pulses", r_ldv, 1);

    // LW with ready held low four cycles.
    run_op(1, 0, 0, 32'h300, 0, 4, 0, 32'h89AB_CDEF);
    check("lw_wait_handshakes", r_hs, 1);
    check("lw_wait_req_cycles", r_reqv, 5);
    check("lw_wait_done_at", r_done_at, 8);
    check("lw_wait_data", load_data_o, 32'h89AB_CDEF);

    // Both flags set behaves as a store.
    run_op(1, 1, 0, 32'h10, 32'h1234_5678, 0, 0, 32'hFFFF_FFFF);
    check("both_done_at", r_done_at, 3);
    check("both_load_v_pulses", r_ldv, 0);
    check("both_keeps_load_data", load_data_o, 32'h89AB_CDEF);

    // LBU lane 0 zero-extends a byte with its top bit set.
    run_op(1, 0, 1, 32'h400, 0, 1, 1, 32'hFFEE_DD80);
    check("lbu0_data", load_data_o, 32'h80);

`ifndef DMEM_MISALIGN_TRAP_EN
    // Misaligned LW: low address bits are dropped.
    run_op(1, 0, 0, 32'h103, 0, 0, 0, 32'hCAFE_F00D);
    check("lw_misal_addr", r_addr, 32'h100);
    check("lw_misal_data", load_data_o, 32'hCAFE_F00D);
`else
    // Misaligned LW traps straight to DONE without a request.
    mem_op_v_i = 1; is_load_op_i = 1; addr_i = 32'h103;
    @(negedge clk);
    check("trap_accept_stall", stall_o, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("trap_done_pulse", {misalign_o, op_done_o, load_data_v_o, mem_req_v_o}, 4'b1100);
    @(posedge clk); #1;
`endif

    // Valid op with neither flag is ignored.
    mem_op_v_i = 1;
    r_stall = 0; r_reqv = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (stall_o) r_stall++;
      if (mem_req_v_o) r_reqv++;
      @(posedge clk); #1;
    end
    idle_inputs();
    check("noflag_stall_cycles", r_stall, 0);
    check("noflag_req_cycles", r_reqv, 0);

    // Reset while in WAIT, then a stray response.
    mem_op_v_i = 1; is_load_op_i = 1; is_byte_op_i = 1; addr_i = 32'h202;
    @(posedge clk); #1;
    mem_op_v_i = 0; mem_req_ready_i = 1;
    @(posedge clk); #1;
    mem_req_ready_i = 0;
    @(posedge clk); #1;
    #2 n_reset = 0;
    @(negedge clk);
    check("wait_rst_outputs", {stall_o, op_done_o, load_data_v_o, mem_req_v_o}, 4'b0000);
    check("wait_rst_load_data", load_data_o, 32'h0);
    check("wait_rst_req_fields", {mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o}, 69'h0);
    @(posedge clk); #1;
    n_reset = 1;
    idle_inputs();
    mem_resp_v_i = 1; mem_resp_data_i = 32'hFFFF_FFFF;
    r_ldv = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (load_data_v_o || op_done_o) r_ldv++;
      @(posedge clk); #1;
    end
    idle_inputs();
    check("stray_resp_pulses", r_ldv, 0);
    check("stray_resp_data", load_data_o, 32'h0);

    // Back-to-back: a fresh SW accepted right after the previous DONE.
    run_op(0, 1, 1, 32'h001, 32'h0000_0037, 0, 0, 0);
    check("sb1_req", {r_addr, r_wdata, r_be}, {32'h0, 32'h3737_3737, 4'b0010});
    run_op(0, 1, 0, 32'h008, 32'h0BAD_F00D, 2, 0, 0);
    check("sw_rd2_done_at", r_done_at, 5);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_access_ctrl
